// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr-to-RGB converter, LANES pixels per beat, 3-stage pipeline.
// Uses a global-stall valid/ready handshake and carries an end-of-line flag alongside the data.
module ycbcr2rgb #(
    parameter int unsigned LANES     = 8,
    parameter int          COEF_CR_R = 359,
    parameter int          COEF_CB_G = 88,
    parameter int          COEF_CR_G = 183,
    parameter int          COEF_CB_B = 454
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [8*LANES-1:0]    i_y,
    input  logic [8*LANES-1:0]    i_cb,
    input  logic [8*LANES-1:0]    i_cr,
    input  logic                  i_valid,
    input  logic                  i_last,
    output logic                  o_ready,
    output logic [24*LANES-1:0]   o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    localparam logic signed [19:0] KCrR = 20'(COEF_CR_R);
    localparam logic signed [19:0] KCbG = 20'(COEF_CB_G);
    localparam logic signed [19:0] KCrG = 20'(COEF_CR_G);
    localparam logic signed [19:0] KCbB = 20'(COEF_CB_B);
    localparam logic signed [19:0] KRnd = 20'sd128;

    logic en;

    logic [LANES-1:0][8:0] y1_q, y1_d;
    logic [LANES-1:0][8:0] cb1_q, cb1_d;
    logic [LANES-1:0][8:0] cr1_q, cr1_d;
    logic                  v1_q, last1_q, last1_d;

    logic [LANES-1:0][19:0] r2_q, r2_d;
    logic [LANES-1:0][19:0] g2_q, g2_d;
    logic [LANES-1:0][19:0] b2_q, b2_d;
    logic                   v2_q, last2_q;

    logic [24*LANES-1:0] d3_q, d3_d;
    logic                v3_q, last3_q;

    // Floor shift by 8, then clamp to 0..255.
    function automatic logic [7:0] sat8(input logic signed [19:0] a);
        logic signed [19:0] s;
        s = a >>> 8;
        if (s < 20'sd0) begin
            return 8'd0;
        end else if (s > 20'sd255) begin
            return 8'hFF;
        end
        return s[7:0];
    endfunction

    assign en      = i_ready | ~v3_q;
    assign o_ready = en;
    assign o_valid = v3_q;
    assign o_last  = last3_q;
    assign o_data  = d3_q;

    always_comb begin
        y1_d    = '0;
        cb1_d   = '0;
        cr1_d   = '0;
        last1_d = i_last & i_valid;
        for (int k = 0; k < LANES; k++) begin
            y1_d[k]  = {1'b0, i_y[8*k +: 8]};
            // 9-bit wrap yields the two's-complement offset value directly.
            cb1_d[k] = {1'b0, i_cb[8*k +: 8]} - 9'd128;
            cr1_d[k] = {1'b0, i_cr[8*k +: 8]} - 9'd128;
        end
    end

    always_comb begin
        logic signed [19:0] ys, cbs, crs;
        r2_d = '0;
        g2_d = '0;
        b2_d = '0;
        ys   = '0;
        cbs  = '0;
        crs  = '0;
        for (int k = 0; k < LANES; k++) begin
            ys      = signed'({3'b000, y1_q[k], 8'h00});
            cbs     = signed'({{11{cb1_q[k][8]}}, cb1_q[k]});
            crs     = signed'({{11{cr1_q[k][8]}}, cr1_q[k]});
            r2_d[k] = ys + KCrR * crs + KRnd;
            g2_d[k] = ys - KCbG * cbs - KCrG * crs + KRnd;
            b2_d[k] = ys + KCbB * cbs + KRnd;
        end
    end

    always_comb begin
        d3_d = '0;
        for (int k = 0; k < LANES; k++) begin
            d3_d[24*k +: 24] = {sat8(r2_q[k]), sat8(g2_q[k]), sat8(b2_q[k])};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            y1_q    <= '0;
            cb1_q   <= '0;
            cr1_q   <= '0;
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            r2_q    <= '0;
            g2_q    <= '0;
            b2_q    <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            d3_q    <= '0;
            v3_q    <= 1'b0;
            last3_q <= 1'b0;
        end else if (en) begin
            y1_q    <= y1_d;
            cb1_q   <= cb1_d;
            cr1_q   <= cr1_d;
            v1_q    <= i_valid;
            last1_q <= last1_d;
            r2_q    <= r2_d;
            g2_q    <= g2_d;
            b2_q    <= b2_d;
            v2_q    <= v1_q;
            last2_q <= last1_q;
            d3_q    <= d3_d;
            v3_q    <= v2_q;
            last3_q <= last2_q;
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Randomized self-checking bench for ycbcr2rgb against an integer BT.601 reference model.
module tb_ycbcr2rgb;

    localparam int LANES = 8;
    localparam int W     = 24 * LANES;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    logic                i_clk;
    logic                i_rst;
    logic [8*LANES-1:0]  i_y;
    logic [8*LANES-1:0]  i_cb;
    logic [8*LANES-1:0]  i_cr;
    logic                i_valid;
    logic                i_last;
    logic                o_ready;
    logic [W-1:0]        o_data;
    logic                o_valid;
    logic                o_last;
    logic                i_ready;

    int    checks;
    int    errors;
    beat_t exp_q[$];
    beat_t got_q[$];

    ycbcr2rgb #(.LANES(LANES)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_y     (i_y),
        .i_cb    (i_cb),
        .i_cr    (i_cr),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] clamp(input int v);
        int s;
        if (v < 0) return 8'd0;
        s = v / 256;
        if (s > 255) return 8'hFF;
        return s[7:0];
    endfunction

    function automatic logic [W-1:0] model(input logic [8*LANES-1:0] y,
                                           input logic [8*LANES-1:0] cb,
                                           input logic [8*LANES-1:0] cr);
        logic [W-1:0] res;
        int yy, cbv, crv;
        res = '0;
        for (int k = 0; k < LANES; k++) begin
            yy  = int'(y[8*k +: 8]);
            cbv = int'(cb[8*k +: 8]) - 128;
            crv = int'(cr[8*k +: 8]) - 128;
            res[24*k+16 +: 8] = clamp(yy * 256 + 359 * crv + 128);
            res[24*k+8  +: 8] = clamp(yy * 256 - 88 * cbv - 183 * crv + 128);
            res[24*k    +: 8] = clamp(yy * 256 + 454 * cbv + 128);
        end
        return res;
    endfunction

    task automatic rand_pixels();
        for (int k = 0; k < LANES; k++) begin
            i_y[8*k +: 8]  = 8'($urandom);
            i_cb[8*k +: 8] = 8'($urandom);
            i_cr[8*k +: 8] = 8'($urandom);
        end
    endtask

    // One clock: record accepted inputs (as model output) and consumed outputs, then step past the edge.
    task automatic cycle();
        beat_t b;
        @(negedge i_clk);
        if (!i_rst) begin
            if (i_valid && o_ready) begin
                b.d = model(i_y, i_cb, i_cr);
                b.l = i_last;
                exp_q.push_back(b);
            end
            if (o_valid && i_ready) begin
                b.d = o_data;
                b.l = o_last;
                got_q.push_back(b);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        repeat (5) cycle();
    endtask

    task automatic test_reset();
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        i_y = '0; i_cb = '0; i_cr = '0;
        i_rst = 1'b1;
        #3;
        checks++;
        if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== '0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset got valid=%b last=%b ready=%b data=%h required 0 0 1 0",
                     o_valid, o_last, o_ready, o_data);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got valid=%b ready=%b required 0 1", o_valid, o_ready);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_neutral();
        i_ready = 1'b1;
        i_y  = {LANES{8'd128}};
        i_cb = {LANES{8'd128}};
        i_cr = {LANES{8'd128}};
        i_valid = 1'b1;
        i_last  = 1'b0;
        cycle();
        i_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (o_valid !== (c == 3) || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL neutral_latency cycle %0d got valid=%b ready=%b required %b 1",
                         c, o_valid, o_ready, c == 3);
            end
            if (c < 3) cycle();
        end
        checks++;
        if (o_data !== {LANES{24'h808080}}) begin
            errors++;
            $display("FAIL neutral_data got %h required all 808080", o_data);
        end
        drain();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_vectors();
        logic [W-1:0]  want;
        logic [23:0]   fixed_exp [4];
        fixed_exp[0] = 24'hEE0E0E;
        fixed_exp[1] = 24'hFFD01C;
        fixed_exp[2] = 24'h002C00;
        fixed_exp[3] = 24'hFFFFFF;
        rand_pixels();
        i_y[7:0]   = 8'd81;  i_cb[7:0]   = 8'd90;  i_cr[7:0]   = 8'd240;
        i_y[15:8]  = 8'd255; i_cb[15:8]  = 8'd0;   i_cr[15:8]  = 8'd255;
        i_y[23:16] = 8'd0;   i_cb[23:16] = 8'd0;   i_cr[23:16] = 8'd128;
        i_y[31:24] = 8'd255; i_cb[31:24] = 8'd128; i_cr[31:24] = 8'd128;
        want = model(i_y, i_cb, i_cr);
        i_ready = 1'b1;
        i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        repeat (2) cycle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data[24*k +: 24] !== fixed_exp[k]) begin
                errors++;
                $display("FAIL vector_lane%0d got valid=%b rgb=%h required 1 %h",
                         k, o_valid, o_data[24*k +: 24], fixed_exp[k]);
            end
        end
        checks++;
        if (o_data !== want) begin
            errors++;
            $display("FAIL vector_all_lanes got %h required %h", o_data, want);
        end
        drain();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_stream();
        logic [W-1:0] want [10];
        i_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                rand_pixels();
                for (int k = 0; k < LANES; k++) i_y[8*k +: 8] = 8'(c * 20 + k);
                want[c] = model(i_y, i_cb, i_cr);
                i_valid = 1'b1;
                i_last  = (c == 9);
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            cycle();
            if (c >= 2 && c <= 11) begin
                checks++;
                if (o_valid !== 1'b1 || o_last !== (c == 11) || o_data !== want[c-2]) begin
                    errors++;
                    $display("FAIL stream_beat%0d got valid=%b last=%b data=%h required 1 %b %h",
                             c - 2, o_valid, o_last, o_data, c == 11, want[c-2]);
                end
            end else if (c == 12) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_end got valid=%b required 0", o_valid);
                end
            end
        end
        drain();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_stall();
        logic [W-1:0] snap;
        logic         snap_last;
        snap = '0;
        snap_last = 1'b0;
        for (int c = 0; c < 14; c++) begin
            rand_pixels();
            i_valid = 1'b1;
            i_last  = 1'($urandom);
            i_ready = !(c >= 5 && c < 10);
            #1;
            if (c >= 5 && c < 10) begin
                checks++;
                if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready cycle %0d got valid=%b ready=%b required 1 0",
                             c, o_valid, o_ready);
                end
                if (c == 5) begin
                    snap = o_data;
                    snap_last = o_last;
                end else begin
                    checks++;
                    if (o_data !== snap || o_last !== snap_last) begin
                        errors++;
                        $display("FAIL stall_hold cycle %0d got %h/%b required %h/%b",
                                 c, o_data, o_last, snap, snap_last);
                    end
                end
            end
            cycle();
        end
        drain();
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ready_after got %b required 1", o_ready);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_count got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d got %h/%b required %h/%b",
                         i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_bubbles();
        logic pv [12];
        logic want_v;
        i_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            rand_pixels();
            if (c < 12) begin
                pv[c]   = (c % 2 == 0);
                i_valid = pv[c];
                i_last  = pv[c] ? 1'($urandom) : 1'b1;
            end else begin
                i_valid = 1'b0;
                i_last  = 1'b1;
            end
            cycle();
            if (c >= 2) begin
                want_v = (c - 2 < 12) ? pv[c-2] : 1'b0;
                checks++;
                if (o_valid !== want_v || (!o_valid && o_last !== 1'b0)) begin
                    errors++;
                    $display("FAIL bubble_pattern cycle %0d got valid=%b last=%b required %b",
                             c, o_valid, o_last, want_v);
                end
            end
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bubble_count got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bubble_beat%0d got %h/%b required %h/%b",
                         i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midstream();
        logic [W-1:0] want;
        i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            rand_pixels();
            i_valid = 1'b1;
            i_last  = 1'b1;
            cycle();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got valid=%b last=%b data=%h required 0 0 0",
                     o_valid, o_last, o_data);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        exp_q.delete();
        got_q.delete();
        for (int c = 0; c < 5; c++) begin
            cycle();
            checks++;
            if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_stale cycle %0d got valid=%b required 0", c, o_valid);
            end
        end
        rand_pixels();
        want = model(i_y, i_cb, i_cr);
        i_valid = 1'b1;
        cycle();
        i_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (o_valid !== (c == 3)) begin
                errors++;
                $display("FAIL midreset_latency cycle %0d got valid=%b required %b",
                         c, o_valid, c == 3);
            end
            if (c < 3) cycle();
        end
        checks++;
        if (o_data !== want) begin
            errors++;
            $display("FAIL midreset_data got %h required %h", o_data, want);
        end
        drain();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_pixels();
            i_valid = ($urandom_range(0, 3) != 0);
            i_last  = 1'($urandom);
            i_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d beats required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat%0d got %h/%b required %h/%b",
                         i, got_q[i].d, got_q[i].l, exp_q[i].d, exp_q[i].l);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_neutral();
        test_vectors();
        test_stream();
        test_stall();
        test_bubbles();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
